// File: rtl/prom_ctrl_pkg.sv
// Shared types and defaults for the PROM access controller.
// Holds the FSM state encoding, default geometry and requester-ID type.
package prom_ctrl_pkg;

   localparam int DEF_ADDR_W    = 2;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_MAX_RETRY = 2;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RDWAIT,
      PROG,
      VRD,
      VCMP,
      RESP
   } state_t;

   typedef logic req_id_t;

   // A zero-retry build still needs a 1-bit counter to stay synthesizable
   function automatic int retry_w(input int max_retry);
      return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer updates on grant.
// Zero latency; grants only while en is high, a losing requester simply waits.
module rr_arb2
   import prom_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output req_id_t    gnt_id
);

   req_id_t last_q;
   logic    fire;

   always_comb begin
      gnt_id = 1'b0;
      if (req[0] && req[1]) begin
         gnt_id = ~last_q;
      end else if (req[1]) begin
         gnt_id = 1'b1;
      end
      fire = en && (req != 2'b00);
      gnt  = {gnt_id, ~gnt_id} & {2{fire}};
   end

   // Pointer resets to 1 so requester 0 wins the first contested grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (fire) begin
         last_q <= gnt_id;
      end
   end

endmodule

// File: rtl/prom_access_ctrl.sv
// Two-requester PROM controller: read, or program+verify with bounded retry.
// Read resp at accept+3, write at accept+4 (+3 per retry); requests wait while busy.
module prom_access_ctrl
   import prom_ctrl_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_RETRY = DEF_MAX_RETRY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              resp0_valid,
   output logic [DATA_W-1:0] resp0_rdata,
   output logic              resp0_err,
   output logic              resp1_valid,
   output logic [DATA_W-1:0] resp1_rdata,
   output logic              resp1_err,
   output logic              prom_cs,
   output logic              prom_read,
   output logic              prom_program,
   output logic [ADDR_W-1:0] prom_addr,
   output logic [DATA_W-1:0] prom_wdata,
   input  logic [DATA_W-1:0] prom_rdata,
   output logic              busy
);

   localparam int                 RETRY_W   = retry_w(MAX_RETRY);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   state_t              state;
   req_id_t             id_q;
   logic [RETRY_W-1:0]  retry_q;

   logic                arb_en;
   logic [1:0]          gnt;
   req_id_t             gnt_id;
   logic                sel_write;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                resp_fire;
   logic                resp_err_nxt;

   // Accept pulses are the only outputs that see req inputs; held low in reset
   assign arb_en = rst_n && (state == IDLE);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (arb_en),
      .req    ({req1_valid, req0_valid}),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   always_comb begin
      sel_write = gnt_id ? req1_write : req0_write;
      sel_addr  = gnt_id ? req1_addr  : req0_addr;
      sel_wdata = gnt_id ? req1_wdata : req0_wdata;
   end

   // Decide in RDWAIT/VCMP whether this cycle's readback completes the request
   always_comb begin
      resp_fire    = 1'b0;
      resp_err_nxt = 1'b0;
      if (state == RDWAIT) begin
         resp_fire = 1'b1;
      end else if (state == VCMP) begin
         if (prom_rdata == prom_wdata) begin
            resp_fire = 1'b1;
         end else if (retry_q == RETRY_MAX) begin
            resp_fire    = 1'b1;
            resp_err_nxt = 1'b1;
         end
      end
   end

   // PROM strobes are registered for the state being entered, so they line
   // up with RD/PROG/VRD; prom_addr/prom_wdata double as the request latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         id_q         <= 1'b0;
         retry_q      <= '0;
         busy         <= 1'b0;
         prom_cs      <= 1'b0;
         prom_read    <= 1'b0;
         prom_program <= 1'b0;
         prom_addr    <= '0;
         prom_wdata   <= '0;
      end else begin
         prom_cs      <= 1'b0;
         prom_read    <= 1'b0;
         prom_program <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt != 2'b00) begin
                  id_q      <= gnt_id;
                  retry_q   <= '0;
                  busy      <= 1'b1;
                  prom_cs   <= 1'b1;
                  prom_addr <= sel_addr;
                  if (sel_write) begin
                     state        <= PROG;
                     prom_program <= 1'b1;
                     prom_wdata   <= sel_wdata;
                  end else begin
                     state     <= RD;
                     prom_read <= 1'b1;
                  end
               end
            end
            RD:     state <= RDWAIT;
            RDWAIT: state <= RESP;
            PROG: begin
               state     <= VRD;
               prom_cs   <= 1'b1;
               prom_read <= 1'b1;
            end
            VRD:    state <= VCMP;
            VCMP: begin
               if (resp_fire) begin
                  state <= RESP;
               end else begin
                  state        <= PROG;
                  retry_q      <= retry_q + RETRY_W'(1);
                  prom_cs      <= 1'b1;
                  prom_program <= 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp0_valid <= 1'b0;
         resp0_rdata <= '0;
         resp0_err   <= 1'b0;
         resp1_valid <= 1'b0;
         resp1_rdata <= '0;
         resp1_err   <= 1'b0;
      end else begin
         resp0_valid <= resp_fire && (id_q == 1'b0);
         resp1_valid <= resp_fire && (id_q == 1'b1);
         if (resp_fire && (id_q == 1'b0)) begin
            resp0_rdata <= prom_rdata;
            resp0_err   <= resp_err_nxt;
         end
         if (resp_fire && (id_q == 1'b1)) begin
            resp1_rdata <= prom_rdata;
            resp1_err   <= resp_err_nxt;
         end
      end
   end

endmodule
